lsu_mem_initiator: RTL and testbench

- Load/store initiator between the MEM pipeline stage and the data memory.
- Takes one load/store command per transaction from the pipeline and checks alignment.
- Issues a word-wide request with byte enables on a req/ack memory port, waits for the acknowledge, then extracts and extends load data.
- Stalls the pipeline while a transaction is outstanding and flags misaligned accesses and bus timeouts.

---
 rtl/lsu_mem_initiator.sv | 177 +++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the MEM stage and a req/ack data memory port.
// Checks alignment, positions byte lanes, waits for ack (with timeout) and extends load data.
module lsu_mem_initiator #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_valid,
   input  logic              cpu_we,
   input  logic [2:0]        cpu_op,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [31:0]       cpu_pc,
   output logic              cpu_busy,
   output logic              cpu_done,
   output logic [31:0]       cpu_rdata,
   output logic [1:0]        cpu_err,
   output logic [31:0]       err_pc,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [2:0]       op_reg;
   logic [1:0]       off_reg;
   logic [31:0]      pc_reg;

   logic [1:0]       off_in;
   logic             is_word;
   logic             is_half;
   logic             is_byte;
   logic             aligned;
   logic [3:0]       be_in;
   logic [31:0]      wdata_in;
   logic [15:0]      lane_data;
   logic [31:0]      load_data;

   assign off_in = cpu_addr[1:0];

   // Undefined opcodes decode to no size at all, so they fall out as misaligned.
   always_comb begin
      is_word = 1'b0;
      is_half = 1'b0;
      is_byte = 1'b0;
      case (cpu_op)
         3'b000:          is_word = 1'b1;
         3'b001, 3'b101:  is_byte = 1'b1;
         3'b010, 3'b110:  is_half = 1'b1;
         default: ;
      endcase
   end

   assign aligned = is_word ? (off_in == 2'b00) :
                    is_half ? !off_in[0]        :
                    is_byte;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign be_in[gi] = is_word
                          | (is_half & (off_in[1] == LANE[1]))
                          | (is_byte & (off_in == LANE));
         assign wdata_in[8*gi +: 8] = is_word ? cpu_wdata[8*gi +: 8]       :
                                      is_half ? cpu_wdata[8*(gi%2) +: 8]   :
                                      cpu_wdata[7:0];
      end
   endgenerate

   // Shift the addressed lane down to bit 0 before extension.
   assign lane_data = 16'(mem_rdata >> {off_reg, 3'b000});

   always_comb begin
      load_data = '0;
      case (op_reg)
         3'b000:  load_data = mem_rdata;
         3'b001:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
         3'b101:  load_data = {24'h0, lane_data[7:0]};
         3'b010:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
         3'b110:  load_data = {16'h0, lane_data[15:0]};
         default: load_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         op_reg    <= '0;
         off_reg   <= '0;
         pc_reg    <= '0;
         cpu_busy  <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_rdata <= '0;
         cpu_err   <= ERR_OK;
         err_pc    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         cpu_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_valid) begin
                  op_reg  <= cpu_op;
                  off_reg <= off_in;
                  pc_reg  <= cpu_pc;
                  if (aligned) begin
                     state     <= REQ;
                     wait_cnt  <= '0;
                     cpu_busy  <= 1'b1;
                     mem_req   <= 1'b1;
                     mem_we    <= cpu_we;
                     mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                     mem_be    <= be_in;
                     mem_wdata <= wdata_in;
                  end else begin
                     // Rejected without touching the bus; completes next cycle.
                     cpu_done  <= 1'b1;
                     cpu_err   <= ERR_ALIGN;
                     cpu_rdata <= '0;
                     err_pc    <= cpu_pc;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  cpu_busy  <= 1'b0;
                  cpu_done  <= 1'b1;
                  cpu_err   <= ERR_OK;
                  cpu_rdata <= mem_we ? 32'h0 : load_data;
               end else if (wait_cnt == CNT_LAST) begin
                  state     <= RESP;
                  mem_req   <= 1'b0;
                  cpu_busy  <= 1'b0;
                  cpu_done  <= 1'b1;
                  cpu_err   <= ERR_TIMEOUT;
                  cpu_rdata <= '0;
                  err_pc    <= pc_reg;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized bench for lsu_mem_initiator with an abstract per-transaction reference model.
module tb_lsu_mem_initiator;

   localparam int TIMEOUT = 16;
   localparam int ADDR_W  = 32;

   logic              clk;
   logic              reset;
   logic              cpu_valid;
   logic              cpu_we;
   logic [2:0]        cpu_op;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_pc;
   logic              cpu_busy;
   logic              cpu_done;
   logic [31:0]       cpu_rdata;
   logic [1:0]        cpu_err;
   logic [31:0]       err_pc;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   int          n_checks;
   int          n_errors;
   logic [31:0] model_err_pc;
   logic [31:0] last_rdata;
   logic [3:0]  last_be;
   logic [31:0] last_wdata;
   logic [31:0] last_addr;

   lsu_mem_initiator #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_valid (cpu_valid),
      .cpu_we    (cpu_we),
      .cpu_op    (cpu_op),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_pc    (cpu_pc),
      .cpu_busy  (cpu_busy),
      .cpu_done  (cpu_done),
      .cpu_rdata (cpu_rdata),
      .cpu_err   (cpu_err),
      .err_pc    (err_pc),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Access size in bytes; 0 marks an undefined opcode.
   function automatic int op_size(input logic [2:0] op);
      case (op)
         3'b000:         return 4;
         3'b001, 3'b101: return 1;
         3'b010, 3'b110: return 2;
         default:        return 0;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input int off, input logic [31:0] word);
      int          size;
      logic [31:0] v;
      logic [31:0] mask;
      size = op_size(op);
      v    = word >> (8 * off);
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v    = v & mask;
      if ((op == 3'b001 || op == 3'b010) && v[8*size-1]) v = v | ~mask;
      return v;
   endfunction

   // ack_delay: index of the request cycle carrying mem_ack, -1 for never.
   task automatic run_txn(input string name, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, input int ack_delay, input logic [31:0] rd);
      int          size;
      int          off;
      int          req_cycles;
      logic        ok;
      logic        timed_out;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_rd;
      logic [1:0]  e_err;
      logic [31:0] t;

      size = op_size(op);
      off  = int'(addr[1:0]);
      ok   = (size != 0) && ((addr % size) == 0);
      e_be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) begin
         if (size != 0) begin
            t = wdata >> (8 * (i % size));
            e_wd[8*i +: 8] = t[7:0];
         end else begin
            e_wd[8*i +: 8] = 8'h00;
         end
      end
      timed_out  = !(ack_delay >= 0 && ack_delay < TIMEOUT);
      req_cycles = timed_out ? TIMEOUT : ack_delay + 1;
      e_err      = timed_out ? 2'b10 : 2'b00;
      e_rd       = (we || timed_out) ? 32'h0 : model_load(op, off, rd);

      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_we    = we;
      cpu_op    = op;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_pc    = pc;
      mem_ack   = 1'b0;
      @(posedge clk);

      if (!ok) begin
         @(negedge clk);
         cpu_valid = 1'b0;
         model_err_pc = pc;
         check({name, "_done"}, 32'(cpu_done), 32'd1);
         check({name, "_err"}, 32'(cpu_err), 32'd1);
         check({name, "_rdata"}, cpu_rdata, 32'h0);
         check({name, "_errpc"}, err_pc, model_err_pc);
         check({name, "_noreq"}, 32'(mem_req), 32'd0);
         check({name, "_nobusy"}, 32'(cpu_busy), 32'd0);
         @(negedge clk);
         check({name, "_idle_req"}, 32'(mem_req), 32'd0);
         check({name, "_idle_done"}, 32'(cpu_done), 32'd0);
         $display("txn %s we=%0d op=%b addr=%h -> misaligned", name, we, op, addr);
         return;
      end

      for (int k = 1; k <= req_cycles; k++) begin
         @(negedge clk);
         check({name, "_req"}, 32'(mem_req), 32'd1);
         check({name, "_busy"}, 32'(cpu_busy), 32'd1);
         check({name, "_early_done"}, 32'(cpu_done), 32'd0);
         check({name, "_addr"}, mem_addr, {addr[31:2], 2'b00});
         check({name, "_be"}, 32'(mem_be), 32'(e_be));
         check({name, "_we"}, 32'(mem_we), 32'(we));
         if (we) check({name, "_wdata"}, mem_wdata, e_wd);
         last_be    = mem_be;
         last_wdata = mem_wdata;
         last_addr  = mem_addr;
         mem_ack   = (k == ack_delay + 1);
         mem_rdata = mem_ack ? rd : $urandom;
      end

      @(negedge clk);
      cpu_valid = 1'b0;
      if (timed_out) model_err_pc = pc;
      check({name, "_done"}, 32'(cpu_done), 32'd1);
      check({name, "_resp_busy"}, 32'(cpu_busy), 32'd0);
      check({name, "_resp_req"}, 32'(mem_req), 32'd0);
      check({name, "_err"}, 32'(cpu_err), 32'(e_err));
      check({name, "_rdata"}, cpu_rdata, e_rd);
      check({name, "_errpc"}, err_pc, model_err_pc);
      last_rdata = cpu_rdata;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      check({name, "_after_done"}, 32'(cpu_done), 32'd0);
      check({name, "_after_req"}, 32'(mem_req), 32'd0);
      $display("txn %s we=%0d op=%b addr=%h ack=%0d -> err=%b rdata=%h", name, we, op, addr,
               ack_delay, e_err, e_rd);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] addr;
      int          sel;
      int          dly;
      logic [2:0]  ops [5];
      ops = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110};

      n_checks = 0;
      n_errors = 0;
      model_err_pc = 32'h0;
      reset     = 1'b0;
      cpu_valid = 1'b0;
      cpu_we    = 1'b0;
      cpu_op    = 3'b000;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_pc    = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(cpu_busy), 32'd0);
      check("rst_done", 32'(cpu_done), 32'd0);
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_err", 32'(cpu_err), 32'd0);
      check("rst_errpc", err_pc, 32'h0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_be", 32'(mem_be), 32'd0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_we", 32'(mem_we), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_txn("sw_word", 1'b1, 3'b000, 32'h100, 32'hDEADBEEF, 32'h1000, 1, 32'h0);
      check("plan_sw_be", 32'(last_be), 32'hF);
      check("plan_sw_addr", last_addr, 32'h100);
      check("plan_sw_wdata", last_wdata, 32'hDEADBEEF);
      run_txn("lw_word", 1'b0, 3'b000, 32'h100, 32'h0, 32'h1004, 1, 32'hDEADBEEF);
      check("plan_lw_rdata", last_rdata, 32'hDEADBEEF);
      run_txn("lb", 1'b0, 3'b001, 32'h103, 32'h0, 32'h1008, 0, 32'h80FF0000);
      check("plan_lb_be", 32'(last_be), 32'h8);
      check("plan_lb_rdata", last_rdata, 32'hFFFFFF80);
      run_txn("lbu", 1'b0, 3'b101, 32'h103, 32'h0, 32'h100C, 0, 32'h80FF0000);
      check("plan_lbu_rdata", last_rdata, 32'h00000080);
      run_txn("sb", 1'b1, 3'b001, 32'h102, 32'h000000AB, 32'h1010, 0, 32'h0);
      check("plan_sb_be", 32'(last_be), 32'h4);
      check("plan_sb_wdata", last_wdata, 32'hABABABAB);
      run_txn("lh", 1'b0, 3'b010, 32'h202, 32'h0, 32'h1014, 0, 32'h80011234);
      check("plan_lh_be", 32'(last_be), 32'hC);
      check("plan_lh_rdata", last_rdata, 32'hFFFF8001);
      run_txn("lhu", 1'b0, 3'b110, 32'h202, 32'h0, 32'h1018, 0, 32'h80011234);
      check("plan_lhu_rdata", last_rdata, 32'h00008001);
      run_txn("lw_mis", 1'b0, 3'b000, 32'h101, 32'h0, 32'h3000, 0, 32'h0);
      check("plan_mis_errpc", err_pc, 32'h3000);
      run_txn("sh_mis", 1'b1, 3'b010, 32'h203, 32'h5555, 32'h3004, 0, 32'h0);
      run_txn("undef_op", 1'b0, 3'b011, 32'h200, 32'h0, 32'h3008, 0, 32'h0);
      run_txn("timeout", 1'b0, 3'b000, 32'h300, 32'h0, 32'h4000, -1, 32'h0);
      check("plan_to_errpc", err_pc, 32'h4000);
      run_txn("ack_last", 1'b0, 3'b000, 32'h304, 32'h0, 32'h4004, TIMEOUT - 1, 32'h12345678);

      // Asynchronous reset while a request is outstanding.
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_we    = 1'b0;
      cpu_op    = 3'b000;
      cpu_addr  = 32'h400;
      cpu_pc    = 32'h5000;
      @(posedge clk);
      @(negedge clk);
      cpu_valid = 1'b0;
      check("rstmid_req_before", 32'(mem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      model_err_pc = 32'h0;
      check("rstmid_req", 32'(mem_req), 32'd0);
      check("rstmid_busy", 32'(cpu_busy), 32'd0);
      check("rstmid_errpc", err_pc, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rstmid_no_done", 32'(cpu_done), 32'd0);
         check("rstmid_no_req", 32'(mem_req), 32'd0);
      end
      $display("txn rst_mid addr=400 -> reset during REQ");
      run_txn("lw_after_rst", 1'b0, 3'b000, 32'h400, 32'h0, 32'h5004, 0, 32'hCAFEF00D);
      check("plan_rst_lw", last_rdata, 32'hCAFEF00D);

      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 19);
         op  = (sel < 18) ? ops[sel % 5] : 3'($urandom);
         addr = $urandom;
         if ($urandom_range(0, 9) < 7 && op_size(op) != 0)
            addr = addr & ~(32'(op_size(op)) - 32'd1);
         sel = $urandom_range(0, 9);
         dly = (sel < 7) ? $urandom_range(0, 3) :
               (sel == 7) ? -1 :
               (sel == 8) ? TIMEOUT - 1 : $urandom_range(4, 10);
         run_txn("rnd", 1'($urandom), op, addr, $urandom, $urandom, dly, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
